data_mem_sized: RTL

DATA_MEM_SIZED -- requirements
Module: data_mem_sized

---
 rtl/data_mem_sized.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/data_mem_sized.sv
// data_mem_sized: single-port 32-bit data memory with byte/half/word access,
// little-endian lanes, registered loads, sticky alignment fault and an
// optional zero-fill sequence after reset.
module data_mem_sized #(
    parameter int DEPTH_LOG2     = 6,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic        ClearFault,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Busy,
    output logic        Misaligned
);

    localparam int Depth = 1 << DEPTH_LOG2;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam state_t ResetState = CLEAR_ON_RESET ? INIT : READY;

    state_t                  state;
    state_t                  nextState;
    logic [DEPTH_LOG2-1:0]   fillCount;
    logic [31:0]             mem [Depth];

    logic [DEPTH_LOG2-1:0]   wordIdx;
    logic                    legal;
    logic                    request;
    logic                    fault;
    logic                    loadFire;
    logic                    storeFire;
    logic [31:0]             loadWord;
    logic [31:0]             shifted;
    logic [31:0]             loadResult;
    logic [31:0]             storeData;
    logic [3:0]              byteEn;
    logic                    unusedAddrBits;

    // Upper address bits are ignored: the address wraps modulo the depth.
    assign wordIdx        = Address[DEPTH_LOG2+1:2];
    assign unusedAddrBits = ^Address[31:DEPTH_LOG2+2];

    assign Busy      = (state == INIT);
    assign legal     = (Size == 2'b00)
                     | ((Size == 2'b01) & ~Address[0])
                     | ((Size == 2'b10) & (Address[1:0] == 2'b00));
    assign request   = (MemRead | MemWrite) & ~Busy;
    assign fault     = request & ~legal;
    assign loadFire  = MemRead & legal & ~Busy;
    assign storeFire = MemWrite & legal & ~Busy;

    // Fill sequencer state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ResetState;
        end else begin
            state <= nextState;
        end
    end

    // Next state: leave INIT once the last word has been zeroed.
    // NOTE: default assigned first so no path through the block infers a latch.
    always_comb begin
        nextState = state;
        if (state == INIT && fillCount == '1) begin
            nextState = READY;
        end
    end

    // Fill counter walks every word index while in INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fillCount <= '0;
        end else if (state == INIT) begin
            fillCount <= fillCount + 1'b1;
        end
    end

    // Load path: pick the addressed lane from the pre-write word and extend it.
    always_comb begin
        loadWord   = mem[wordIdx];
        shifted    = loadWord >> {Address[1:0], 3'b000};
        loadResult = loadWord;
        case (Size)
            2'b00:   loadResult = {{24{shifted[7] & ~Unsigned}}, shifted[7:0]};
            2'b01:   loadResult = {{16{shifted[15] & ~Unsigned}}, shifted[15:0]};
            default: loadResult = loadWord;
        endcase
    end

    // Store path: replicate the right-justified data across lanes and enable the addressed ones.
    always_comb begin
        storeData = WriteData;
        byteEn    = 4'hF;
        case (Size)
            2'b00: begin
                storeData = {4{WriteData[7:0]}};
                byteEn    = 4'b0001 << Address[1:0];
            end
            2'b01: begin
                storeData = {2{WriteData[15:0]}};
                byteEn    = 4'b0011 << Address[1:0];
            end
            default: begin
                storeData = WriteData;
                byteEn    = 4'hF;
            end
        endcase
    end

    // Memory array: zero-fill during INIT, lane-masked stores afterwards.
    // NOTE: the array has no reset; clearing it is the fill sequencer's job, one word per cycle.
    always_ff @(posedge clk) begin
        if (Busy) begin
            mem[fillCount] <= '0;
        end else if (storeFire) begin
            for (int k = 0; k < 4; k++) begin
                if (byteEn[k]) begin
                    mem[wordIdx][8*k +: 8] <= storeData[8*k +: 8];
                end
            end
        end
    end

    // Registered load result; data forced to zero whenever it is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData  <= '0;
            ReadValid <= 1'b0;
        end else begin
            ReadValid <= loadFire;
            ReadData  <= loadFire ? loadResult : '0;
        end
    end

    // Sticky fault flag; a new fault wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Misaligned <= 1'b0;
        end else if (fault) begin
            Misaligned <= 1'b1;
        end else if (ClearFault) begin
            Misaligned <= 1'b0;
        end
    end

endmodule
